// File: rtl/alu_status_pkg.sv
// Shared types, bit positions and condition evaluation for the ALU status register.
package alu_status_pkg;

   localparam int unsigned FLAG_C = 0;
   localparam int unsigned FLAG_Z = 1;
   localparam int unsigned FLAG_S = 2;
   localparam int unsigned FLAG_O = 3;
   localparam int unsigned FLAG_W = 4;

   // Packed so that bit0=C, bit1=Z, bit2=S, bit3=O.
   typedef struct packed {
      logic o;
      logic s;
      logic z;
      logic c;
   } flags_t;

   typedef enum logic [3:0] {
      CondZ  = 4'd0,
      CondNz = 4'd1,
      CondC  = 4'd2,
      CondNc = 4'd3,
      CondS  = 4'd4,
      CondNs = 4'd5,
      CondO  = 4'd6,
      CondNo = 4'd7,
      CondGe = 4'd8,
      CondLt = 4'd9,
      CondGt = 4'd10,
      CondLe = 4'd11,
      CondAl = 4'd12
   } cond_e;

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StRestore = 2'd1,
      StError   = 2'd2
   } state_e;

   function automatic logic eval_cond(flags_t f, logic [3:0] sel);
      logic r;
      r = 1'b0;
      case (cond_e'(sel))
         CondZ:   r = f.z;
         CondNz:  r = !f.z;
         CondC:   r = f.c;
         CondNc:  r = !f.c;
         CondS:   r = f.s;
         CondNs:  r = !f.s;
         CondO:   r = f.o;
         CondNo:  r = !f.o;
         CondGe:  r = (f.s == f.o);
         CondLt:  r = (f.s != f.o);
         CondGt:  r = !f.z && (f.s == f.o);
         CondLe:  r = f.z || (f.s != f.o);
         CondAl:  r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_status_stack.sv
// LIFO of saved status words; the pointer counts occupied entries and rdata shows
// the entry at the pointer, i.e. the one just popped.
module alu_status_stack
   import alu_status_pkg::*;
#(
   parameter int unsigned STACK_DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(STACK_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_en,
   input  logic              pop_en,
   input  logic [FLAG_W-1:0] wdata,
   output logic [FLAG_W-1:0] rdata,
   output logic [PTR_W-1:0]  ptr,
   output logic              full,
   output logic              empty
);

   localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
   localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(STACK_DEPTH);

   logic [FLAG_W-1:0] mem [STACK_DEPTH];
   logic [PTR_W-1:0]  ptr_q;
   logic [IDX_W-1:0]  idx;

   // ptr_q == STACK_DEPTH has no backing entry; park the index on 0 there.
   assign idx   = (ptr_q < DEPTH_P) ? ptr_q[IDX_W-1:0] : '0;
   assign full  = (ptr_q == DEPTH_P);
   assign empty = (ptr_q == '0);
   assign ptr   = ptr_q;
   assign rdata = mem[idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (push_en && !full) begin
         ptr_q <= ptr_q + PTR_W'(1);
      end else if (pop_en && !empty) begin
         ptr_q <= ptr_q - PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_en && !full) begin
         mem[idx] <= wdata;
      end
   end

endmodule

// File: rtl/alu_status_reg.sv
// ALU status register with masked flag updates, a save/restore LIFO and condition evaluation.
// Optional sticky overflow (so_flag/so_clr) is built when ALU_STATUS_STICKY_OV_EN is defined.
module alu_status_reg
   import alu_status_pkg::*;
#(
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flag_valid,
   output logic       flag_ready,
   input  logic [2:0] opsel,
   input  logic       mode,
   input  logic       c_flag,
   input  logic       z_flag,
   input  logic       s_flag,
   input  logic       o_flag,
   input  logic       push,
   input  logic       pop,
   input  logic       err_clr,
   input  logic [3:0] cond_sel,
`ifdef ALU_STATUS_STICKY_OV_EN
   input  logic       so_clr,
   output logic       so_flag,
`endif
   output logic [3:0] flags_q,
   output logic       cond_true,
   output logic       stack_full,
   output logic       stack_empty,
   output logic       stack_err
);

   localparam int unsigned PTR_W = $clog2(STACK_DEPTH + 1);

   localparam logic [1:0] ST_RUN     = StRun;
   localparam logic [1:0] ST_RESTORE = StRestore;
   localparam logic [1:0] ST_ERROR   = StError;

   logic [1:0]        state_q, state_d;
   flags_t            status_q, status_d;
   flags_t            new_flags;
   logic              err_q, err_d;
   logic              upd_en;
   logic              stk_push, stk_pop;
   logic              stk_full, stk_empty;
   logic [FLAG_W-1:0] stk_rdata;
   logic [PTR_W-1:0]  stk_ptr;

   alu_status_stack #(
      .STACK_DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_en (stk_push),
      .pop_en  (stk_pop),
      .wdata   (status_q),
      .rdata   (stk_rdata),
      .ptr     (stk_ptr),
      .full    (stk_full),
      .empty   (stk_empty)
   );

   assign flag_ready = (state_q == ST_RUN) && !pop && !push;
   assign upd_en     = flag_valid && flag_ready && (opsel != 3'b111);

   // mode=1 ops only define Z and S; C and O carry over.
   always_comb begin
      new_flags   = status_q;
      new_flags.z = z_flag;
      new_flags.s = s_flag;
      if (!mode) begin
         new_flags.c = c_flag;
         new_flags.o = o_flag;
      end
   end

   always_comb begin
      state_d  = state_q;
      status_d = status_q;
      err_d    = err_q;
      stk_push = 1'b0;
      stk_pop  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (push && pop) begin
               err_d   = 1'b1;
               state_d = ST_ERROR;
            end else if (push) begin
               if (stk_full) begin
                  err_d   = 1'b1;
                  state_d = ST_ERROR;
               end else begin
                  stk_push = 1'b1;
               end
            end else if (pop) begin
               if (stk_empty) begin
                  err_d   = 1'b1;
                  state_d = ST_ERROR;
               end else begin
                  stk_pop = 1'b1;
                  state_d = ST_RESTORE;
               end
            end else if (upd_en) begin
               status_d = new_flags;
            end
         end
         ST_RESTORE: begin
            status_d = flags_t'(stk_rdata);
            state_d  = ST_RUN;
         end
         ST_ERROR: begin
            if (err_clr) begin
               err_d   = 1'b0;
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         status_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         status_q <= status_d;
         err_q    <= err_d;
      end
   end

   assign flags_q     = status_q;
   assign cond_true   = eval_cond(status_q, cond_sel);
   assign stack_full  = stk_full;
   assign stack_empty = stk_empty;
   assign stack_err   = err_q;

   ptr_in_range: assert property (@(posedge clk) disable iff (!rst_n)
      (stk_ptr <= PTR_W'(STACK_DEPTH)) && (stk_full == (stk_ptr == PTR_W'(STACK_DEPTH))));

`ifdef ALU_STATUS_STICKY_OV_EN
   logic so_q;

   // A new overflow wins over a clear arriving in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         so_q <= 1'b0;
      end else if (upd_en && !mode && o_flag) begin
         so_q <= 1'b1;
      end else if (so_clr) begin
         so_q <= 1'b0;
      end
   end

   assign so_flag = so_q;
`endif

endmodule

// File: tb/tb_alu_status_reg.sv
// Randomised scoreboard bench for alu_status_reg against a queue-based reference model.
module tb_alu_status_reg;

   localparam int unsigned DEPTH = 4;
   localparam int M_RUN     = 0;
   localparam int M_RESTORE = 1;
   localparam int M_ERROR   = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flag_valid, flag_ready;
   logic [2:0] opsel;
   logic       mode, c_flag, z_flag, s_flag, o_flag;
   logic       push, pop, err_clr;
   logic [3:0] cond_sel, flags_q;
   logic       cond_true, stack_full, stack_empty, stack_err;
`ifdef ALU_STATUS_STICKY_OV_EN
   logic       so_clr, so_flag;
`endif

   always #5 clk = ~clk;

   alu_status_reg #(
      .STACK_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flag_valid  (flag_valid),
      .flag_ready  (flag_ready),
      .opsel       (opsel),
      .mode        (mode),
      .c_flag      (c_flag),
      .z_flag      (z_flag),
      .s_flag      (s_flag),
      .o_flag      (o_flag),
      .push        (push),
      .pop         (pop),
      .err_clr     (err_clr),
      .cond_sel    (cond_sel),
`ifdef ALU_STATUS_STICKY_OV_EN
      .so_clr      (so_clr),
      .so_flag     (so_flag),
`endif
      .flags_q     (flags_q),
      .cond_true   (cond_true),
      .stack_full  (stack_full),
      .stack_empty (stack_empty),
      .stack_err   (stack_err)
   );

   typedef struct {
      logic [3:0] flags;
      logic       ready;
      logic       cond;
      logic       full;
      logic       empty;
      logic       err;
      logic       so;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model: flags as a plain nibble {O,S,Z,C}, LIFO as a queue.
   logic [3:0] m_flags;
   logic [3:0] m_stack[$];
   logic [3:0] m_pending;
   int         m_state;
   bit         m_err;
   bit         m_so;

   function automatic logic cond_of(logic [3:0] f, logic [3:0] sel);
      logic c, z, s, o;
      c = f[0]; z = f[1]; s = f[2]; o = f[3];
      case (sel)
         4'd0:    return z;
         4'd1:    return !z;
         4'd2:    return c;
         4'd3:    return !c;
         4'd4:    return s;
         4'd5:    return !s;
         4'd6:    return o;
         4'd7:    return !o;
         4'd8:    return s == o;
         4'd9:    return s != o;
         4'd10:   return !z && (s == o);
         4'd11:   return z || (s != o);
         4'd12:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_flags = 4'b0000;
      m_stack.delete();
      m_pending = 4'b0000;
      m_state = M_RUN;
      m_err = 1'b0;
      m_so = 1'b0;
   endtask

   task automatic model_clock(input bit fv, input logic [2:0] op, input bit md,
                              input logic [3:0] f, input bit ps, input bit pp,
                              input bit ec, input bit sc);
      bit accepted;
      accepted = (m_state == M_RUN) && fv && !ps && !pp;
      if (accepted && op != 3'b111 && !md && f[3]) m_so = 1'b1;
      else if (sc) m_so = 1'b0;
      case (m_state)
         M_RUN: begin
            if (ps && pp) begin
               m_err = 1'b1; m_state = M_ERROR;
            end else if (ps) begin
               if (m_stack.size() == DEPTH) begin
                  m_err = 1'b1; m_state = M_ERROR;
               end else begin
                  m_stack.push_back(m_flags);
               end
            end else if (pp) begin
               if (m_stack.size() == 0) begin
                  m_err = 1'b1; m_state = M_ERROR;
               end else begin
                  m_pending = m_stack.pop_back();
                  m_state = M_RESTORE;
               end
            end else if (fv && op != 3'b111) begin
               m_flags = md ? {m_flags[3], f[2], f[1], m_flags[0]} : f;
            end
         end
         M_RESTORE: begin
            m_flags = m_pending;
            m_state = M_RUN;
         end
         default: begin
            if (ec) begin
               m_err = 1'b0; m_state = M_RUN;
            end
         end
      endcase
   endtask

   // One clock of stimulus; f is {O,S,Z,C}.
   task automatic step(input bit rst, input bit fv, input logic [2:0] op, input bit md,
                       input logic [3:0] f, input bit ps, input bit pp, input bit ec,
                       input logic [3:0] cs, input bit sc);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = rst;
      flag_valid = fv;
      opsel = op;
      mode = md;
      {o_flag, s_flag, z_flag, c_flag} = f;
      push = ps;
      pop = pp;
      err_clr = ec;
      cond_sel = cs;
`ifdef ALU_STATUS_STICKY_OV_EN
      so_clr = sc;
`endif
      if (!rst) model_reset();
      e.flags = m_flags;
      e.ready = (m_state == M_RUN) && !ps && !pp;
      e.cond  = cond_of(m_flags, cs);
      e.full  = (m_stack.size() == DEPTH);
      e.empty = (m_stack.size() == 0);
      e.err   = m_err;
      e.so    = m_so;
      exp_q.push_back(e);
      if (rst) model_clock(fv, op, md, f, ps, pp, ec, sc);
   endtask

   task automatic go(input bit fv, input logic [2:0] op, input bit md, input logic [3:0] f,
                     input bit ps, input bit pp, input bit ec, input logic [3:0] cs);
      step(1'b1, fv, op, md, f, ps, pp, ec, cs, 1'b0);
   endtask

   task automatic idle(input logic [3:0] cs);
      step(1'b1, 1'b0, 3'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, cs, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 3'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 15)), 1'b0);
   endtask

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] want);
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s: got %b, expected %b (vector %0d, t=%0t)", name, act, want, vectors,
                  $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         check("flags_q", flags_q, e.flags);
         check("flag_ready", {3'b000, flag_ready}, {3'b000, e.ready});
         check("cond_true", {3'b000, cond_true}, {3'b000, e.cond});
         check("stack_full", {3'b000, stack_full}, {3'b000, e.full});
         check("stack_empty", {3'b000, stack_empty}, {3'b000, e.empty});
         check("stack_err", {3'b000, stack_err}, {3'b000, e.err});
`ifdef ALU_STATUS_STICKY_OV_EN
         check("so_flag", {3'b000, so_flag}, {3'b000, e.so});
`endif
      end
   end

   initial begin
      rst_n = 1'b0;
      flag_valid = 1'b0; opsel = 3'd0; mode = 1'b0;
      c_flag = 1'b0; z_flag = 1'b0; s_flag = 1'b0; o_flag = 1'b0;
      push = 1'b0; pop = 1'b0; err_clr = 1'b0; cond_sel = 4'd0;
`ifdef ALU_STATUS_STICKY_OV_EN
      so_clr = 1'b0;
`endif
      model_reset();

      // Reset values and condition evaluation on all-zero flags.
      for (int i = 0; i < 4; i++) do_reset();
      idle(4'd1);

      // Full update then condition GE; partial (mode=1) update.
      go(1'b1, 3'd0, 1'b0, 4'b1101, 1'b0, 1'b0, 1'b0, 4'd8);
      idle(4'd8);
      go(1'b1, 3'd2, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 4'd10);
      idle(4'd11);
      go(1'b1, 3'd7, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0);
      idle(4'd0);

      // Save, overwrite, restore two cycles after pop.
      go(1'b1, 3'd0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 4'd0);
      go(1'b0, 3'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd0);
      go(1'b1, 3'd0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'd2);
      go(1'b1, 3'd0, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 4'd2);
      go(1'b1, 3'd0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 4'd1);
      idle(4'd1);

      // Overflow the LIFO, poke while in ERROR, then clear.
      do_reset();
      for (int i = 0; i < 5; i++) go(1'b0, 3'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd12);
      go(1'b1, 3'd0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 4'd0);
      go(1'b0, 3'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'd0);
      go(1'b0, 3'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'd0);
      idle(4'd0);

      // Push and pop together; LIFO preserved across the error.
      do_reset();
      go(1'b1, 3'd0, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 4'd4);
      go(1'b0, 3'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd4);
      go(1'b0, 3'd0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'd4);
      go(1'b0, 3'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'd4);
      go(1'b1, 3'd0, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 4'd6);
      go(1'b0, 3'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'd6);
      idle(4'd4);
      idle(4'd4);
      go(1'b0, 3'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'd0);
      go(1'b0, 3'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'd0);

      // Sticky overflow: survives O=0 update; set wins over simultaneous clear.
      go(1'b1, 3'd1, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 4'd6);
      go(1'b1, 3'd1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd6);
      idle(4'd7);
      step(1'b1, 1'b1, 3'd1, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 4'd6, 1'b1);
      step(1'b1, 1'b0, 3'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd6, 1'b1);
      idle(4'd6);

      // Reset arriving while a restore is pending.
      go(1'b1, 3'd0, 1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, 4'd0);
      go(1'b0, 3'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd0);
      go(1'b0, 3'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'd0);
      do_reset();
      idle(4'd0);
      idle(4'd0);

      for (int i = 0; i < 3000; i++) begin
         step(bit'($urandom_range(0, 199) != 0),
              bit'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)),
              bit'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)),
              bit'($urandom_range(0, 4) == 0),
              bit'($urandom_range(0, 5) == 0),
              bit'($urandom_range(0, 3) == 0),
              4'($urandom_range(0, 15)),
              bit'($urandom_range(0, 7) == 0));
      end

      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected entries left unchecked, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_status_reg.md
ALU_STATUS_REG -- requirements
Module: alu_status_reg

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 4; saved-flag LIFO depth, legal range 2..16.
REQ-002 SHALL have port clk, input, 1; single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1; reset, asynchronous and active-low.
REQ-004 SHALL have port flag_valid, input, 1; the c/z/s/o inputs carry a new flag result.
REQ-005 SHALL have port flag_ready, output, 1; the flag update is accepted this cycle.
REQ-006 SHALL have ports opsel (input, 3) and mode (input, 1); the op that produced the flags.
REQ-007 SHALL have ports c_flag, z_flag, s_flag and o_flag, each input, 1; flags from the flag generator.
REQ-008 SHALL have ports push and pop, each input, 1; save and restore requests for the status word.
REQ-009 SHALL have port err_clr, input, 1; clears the error condition.
REQ-010 SHALL have port cond_sel, input, 4; condition code to evaluate.
REQ-011 SHALL have port flags_q, output, 4; status word, bit0=C, bit1=Z, bit2=S, bit3=O.
REQ-012 SHALL have port cond_true, output, 1; result of evaluating cond_sel.
REQ-013 SHALL have ports stack_full, stack_empty and stack_err, each output, 1; LIFO status.

Function
REQ-014 SHALL implement FSM states RUN, RESTORE and ERROR.
REQ-015 SHALL drive flag_ready = (state==RUN) && !pop && !push.
REQ-016 SHALL write flags on flag_valid && flag_ready, visible on flags_q the next cycle.
REQ-017 SHALL apply update masks: opsel==3'b111 writes nothing; mode=0 writes all four flags; mode=1 writes Z and S only and holds C and O.
REQ-018 SHALL, on push in RUN (not full, no pop), write the current flags_q to the LIFO and increment the pointer.
REQ-019 SHALL, on pop in RUN (not empty, no push), decrement the pointer and enter RESTORE.
REQ-020 SHALL, in RESTORE, load the popped entry into flags_q at the cycle end and return to RUN, so restored flags are visible 2 cycles after pop.
REQ-021 SHALL, on push when full, pop when empty, or push and pop together in RUN, leave the LIFO and flags_q unchanged, set stack_err and enter ERROR.
REQ-022 SHALL, in ERROR, ignore push, pop and flag_valid; err_clr returns the FSM to RUN, clears stack_err and preserves the LIFO contents.
REQ-023 SHALL evaluate cond_true combinationally from flags_q: 0 Z; 1 !Z; 2 C; 3 !C; 4 S; 5 !S; 6 O; 7 !O; 8 S==O; 9 S!=O; 10 !Z&&S==O; 11 Z||S!=O; 12 1; 13-15 0.
REQ-024 SHALL drive stack_full when the pointer equals STACK_DEPTH and stack_empty when it equals 0.

Reset
REQ-025 SHALL, while rst_n=0, drive flags_q=4'b0000, stack_err=0, stack_empty=1, stack_full=0, the FSM to RUN and the pointer to 0.
REQ-026 SHALL, on reset mid-RESTORE, abort the load immediately; LIFO entry contents are don't-care.
REQ-027 SHALL drive cond_true after reset as cond_sel evaluated on all-zero flags.

Configuration
REQ-028 SHALL, with macro ALU_STATUS_STICKY_OV_EN defined, add output so_flag (1 bit) and input so_clr (1 bit).
REQ-029 SHALL set so_flag on any accepted update writing O=1, clear it only on so_clr or reset, and give set priority over so_clr in the same cycle.
REQ-030 SHALL, without the macro, omit the so_flag and so_clr ports and their logic entirely.

Structure
REQ-031 SHALL place the flag-word struct, the cond_sel enum, the FSM state enum and the bit-index constants in package alu_status_pkg.
REQ-032 SHALL implement the LIFO as sub-module alu_status_stack, parameterised by STACK_DEPTH, with full/empty/pointer outputs.

Verification
REQ-033 SHALL cover: flag_valid with mode=0, opsel=000, C=1 Z=0 S=1 O=1 -> flags_q=4'b1101 next cycle; cond_sel=8 -> cond_true=1.
REQ-034 SHALL cover: flags_q=4'b1101, then mode=1 update with Z=1 S=0 -> flags_q=4'b1011.
REQ-035 SHALL cover: push at flags_q=4'b0010, update to 4'b0001, pop -> flag_ready=0 for 2 cycles, flags_q=4'b0010 two cycles after pop.
REQ-036 SHALL cover: 5 pushes with STACK_DEPTH=4 -> stack_full after the 4th, stack_err=1 and ERROR after the 5th, flag_ready=0 until err_clr.
REQ-037 SHALL cover: push and pop in the same cycle -> stack_err=1, pointer unchanged.
REQ-038 SHALL cover: with ALU_STATUS_STICKY_OV_EN, O=1 update then O=0 update -> so_flag stays 1; so_clr with a simultaneous O=1 update -> so_flag=1.
